// File: rtl/onehot_led_decoder.sv
// Buffers {flag, index} codes in a small FIFO and replays each one as a registered
// one-hot LED pattern, holding every pattern for HOLD_CYCLES cycles.
module onehot_led_decoder #(
  parameter int CODE_W      = 3,
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic                          in_flag,
  input  logic [CODE_W-1:0]             in_code,
  output logic                          in_ready,
  output logic [(2**CODE_W)-1:0]        led,
  output logic [CODE_W-1:0]             shown_code,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int N  = 2**CODE_W;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, SHOW = 1'b1} state_t;

  function automatic logic [N-1:0] decode_led(input logic flag, input logic [CODE_W-1:0] code);
    logic [N-1:0] one_s;
    one_s = {{(N-1){1'b0}}, 1'b1};
    if (flag) begin
      decode_led = one_s << code;
    end else begin
      decode_led = {N{1'b0}};
    end
  endfunction

  state_t              state_q, state_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [N-1:0]        led_q, led_d;
  logic [CODE_W-1:0]   shown_q, shown_d;
  logic [LW-1:0]       level_q, level_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CODE_W:0]     mem_q [FIFO_DEPTH];
  logic [CODE_W:0]     mem_d [FIFO_DEPTH];
  logic [CODE_W:0]     head_s;
  logic                push_s, pop_s;

  // Ready looks only at the registered level, so a same-cycle pop never frees a full FIFO.
  assign in_ready = !rst && (level_q != LW'(FIFO_DEPTH));
  assign push_s   = in_valid && in_ready;
  assign head_s   = mem_q[rd_ptr_q];

  // Display FSM: pops the head and reloads with no gap cycle when the hold expires.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    led_d   = led_q;
    shown_d = shown_q;
    pop_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (level_q != {LW{1'b0}}) begin
          pop_s   = 1'b1;
          led_d   = decode_led(head_s[CODE_W], head_s[CODE_W-1:0]);
          shown_d = head_s[CODE_W-1:0];
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = SHOW;
        end else begin
          state_d = IDLE;
        end
      end
      SHOW: begin
        if (hold_q != {HW{1'b0}}) begin
          hold_d = hold_q - HW'(1);
        end else if (level_q != {LW{1'b0}}) begin
          pop_s   = 1'b1;
          led_d   = decode_led(head_s[CODE_W], head_s[CODE_W-1:0]);
          shown_d = head_s[CODE_W-1:0];
          hold_d  = HW'(HOLD_CYCLES - 1);
          state_d = SHOW;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = {in_flag, in_code};
    end else begin
      mem_d = mem_q;
    end
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    level_d  = level_q + LW'(push_s) - LW'(pop_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hold_q   <= {HW{1'b0}};
      led_q    <= {N{1'b0}};
      shown_q  <= {CODE_W{1'b0}};
      level_q  <= {LW{1'b0}};
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      led_q    <= led_d;
      shown_q  <= shown_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign led        = led_q;
  assign shown_code = shown_q;
  assign busy       = (state_q == SHOW);
  assign level      = level_q;

endmodule
